// File: rtl/seven_seg_scan_pkg.sv
// seven_seg_scan_pkg: segment patterns and display constants shared by the scanner and decoder
package seven_seg_scan_pkg;
    // Active-low cathode patterns, bit order g,f,e,d,c,b,a
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_A    = 7'h08;
    localparam logic [6:0] SEG_B    = 7'h03;
    localparam logic [6:0] SEG_C    = 7'h46;
    localparam logic [6:0] SEG_D    = 7'h21;
    localparam logic [6:0] SEG_E    = 7'h06;
    localparam logic [6:0] SEG_F    = 7'h0E;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [3:0] AN_OFF   = 4'hF;
endpackage

// File: rtl/seven_seg_scan_seg_decode.sv
// seg_decode: nibble to active-low 7-segment pattern
//   nibble  in  4  value to show
//   hex_en  in  1  1: 10..15 show A..F, 0: they show a dash
//   seg     out 7  active-low cathodes g,f,e,d,c,b,a
module seg_decode
    import seven_seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_en,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = hex_en ? SEG_A : SEG_DASH;
            4'hB: seg = hex_en ? SEG_B : SEG_DASH;
            4'hC: seg = hex_en ? SEG_C : SEG_DASH;
            4'hD: seg = hex_en ? SEG_D : SEG_DASH;
            4'hE: seg = hex_en ? SEG_E : SEG_DASH;
            4'hF: seg = hex_en ? SEG_F : SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexes four frame-latched BCD/hex digits onto a common-anode display
//   clk       in  1   system clock
//   rst       in  1   asynchronous active-high reset
//   digit_in  in  16  four nibbles, [3:0] is the rightmost position
//   dot_in    in  4   decimal point request per position
//   blank     in  1   turns all anodes off while the scan keeps running
//   an        out 4   anode enables, active low, an[0] rightmost
//   seg       out 7   cathodes g..a, active low
//   dp        out 1   decimal point cathode, active low
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int SCAN_CYCLES = 100000,
    parameter bit HEX_EN      = 1'b0,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digit_in,
    input  logic [3:0]  dot_in,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int TW = $clog2(SCAN_CYCLES);

    logic [TW-1:0] tick_cnt;
    logic [1:0]    pos;
    logic [15:0]   sh_dig;
    logic [3:0]    sh_dot;
    logic          tick;
    logic [3:0]    lz;
    logic          run;
    logic [3:0]    cur_nib;
    logic [6:0]    dec_seg;
    logic          off;

    assign tick    = tick_cnt == TW'(SCAN_CYCLES - 1);
    assign cur_nib = sh_dig[{pos, 2'b00} +: 4];

    // A position is a leading zero while it and everything above it is zero with no dot;
    // a dot anywhere at or above breaks the run, so lower zeros stay visible.
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            run   = run && sh_dig[4*i +: 4] == 4'h0 && !sh_dot[i];
            lz[i] = run;
        end
    end

    assign off = blank || (BLANK_LZ && lz[pos]);

    seg_decode u_dec (
        .nibble (cur_nib),
        .hex_en (HEX_EN),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            pos      <= '0;
            sh_dig   <= '0;
            sh_dot   <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            pos      <= pos + {1'b0, tick};
            // Capture only on the last tick of pos 3 so a frame is never torn
            if (tick && pos == 2'd3) begin
                sh_dig <= digit_in;
                sh_dot <= dot_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= off ? AN_OFF : ~(4'b0001 << pos);
            seg <= off ? SEG_OFF : dec_seg;
            dp  <= off ? 1'b1 : ~sh_dot[pos];
        end
    end
endmodule
